// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared types and constants for the immediate-extension pipe.
package imm_ext_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        EXT_ZERO   = 2'b00,
        EXT_SIGN   = 2'b01,
        EXT_UPPER  = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_mode_t;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// imm_ext_pipe_if: decode-side and execute-side handshakes of imm_ext_pipe.
// master = producer/consumer environment, slave = the extension pipe.
interface imm_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                            flush;
    logic                            in_valid;
    logic                            in_ready;
    logic [imm_ext_pkg::MODE_W-1:0]  in_mode;
    logic [IN_W-1:0]                 in_imm;
    logic                            out_valid;
    logic                            out_ready;
    logic [OUT_W-1:0]                out_data;
    logic [CNT_W-1:0]                occupancy;

    modport master (
        output flush, in_valid, in_mode, in_imm, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_mode, in_imm, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/imm_ext_fifo.sv
// imm_ext_fifo: DEPTH x W buffer with registered ready, count and flush.
// Flush has priority over push and pop; push is only honoured while ready.
module imm_ext_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && ready_q && !flush;
    assign pop_ok_s  = pop && (count_q != CNT_W'(0)) && !flush;

    // Next-state for pointers, count, storage and the registered ready flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
        // Ready looks only at the next registered count, never at pop directly.
        ready_d = (count_d != CNT_W'(DEPTH));
    end

    // State registers; ready stays low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            ready_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= W'(0);
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            mem_q    <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign ready   = ready_q;

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate extension (zero/sign/upper/branch) feeding a
// small output buffer between decode and execute.
// Optional feature macro: IMM_BRANCH_MODE_EN enables the branch-offset mode
// (sign-extend then shift left by 2); without it mode 11 behaves as ZERO.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    imm_ext_pipe_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [OUT_W-1:0] zext_s;
    logic [OUT_W-1:0] sext_s;
    logic [OUT_W-1:0] ext_s;
    logic [CNT_W-1:0] count_s;
    logic             ready_s;

    assign zext_s = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};
    assign sext_s = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};

    // Select the extended operand; UPPER drops any bits shifted past OUT_W.
    always_comb begin
        ext_s = zext_s;
        case (ext_mode_t'(bus.in_mode))
            EXT_ZERO:   ext_s = zext_s;
            EXT_SIGN:   ext_s = sext_s;
            EXT_UPPER:  ext_s = zext_s << (OUT_W - IN_W);
`ifdef IMM_BRANCH_MODE_EN
            EXT_BRANCH: ext_s = sext_s << 2'd2;
`else
            EXT_BRANCH: ext_s = zext_s;
`endif
            default:    ext_s = zext_s;
        endcase
    end

    imm_ext_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (bus.flush),
        .push    (bus.in_valid),
        .pop     (bus.out_ready),
        .wr_data (ext_s),
        .rd_data (bus.out_data),
        .count   (count_s),
        .ready   (ready_s)
    );

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = (count_s != CNT_W'(0));
    assign bus.occupancy = count_s;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed vectors with a scoreboard queue; a negedge
// monitor pops expected operands whenever the pipe hands one over.
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [31:0] exp_q [$];

    logic [15:0] wrap_imm [10] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h1234,
                                   16'hABCD, 16'h0001, 16'hFFFE, 16'h4000, 16'hC000};
    logic [31:0] wrap_exp [10] = '{32'hFFFF8000, 32'h00007FFF, 32'hFFFFFFFF, 32'h00000000,
                                   32'h00001234, 32'hFFFFABCD, 32'h00000001, 32'hFFFFFFFE,
                                   32'h00004000, 32'hFFFFC000};

    imm_ext_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

    imm_ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Output monitor: a handshake seen at negedge completes on the next posedge.
    always @(negedge clk) begin
        if (rst_n && !bus.flush && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got %h, expected no output", bus.out_data);
            end else begin
                chk("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    // One-shot push; records the expected operand when the pipe accepts it.
    task automatic send(input logic [1:0] mode, input logic [15:0] imm, input logic [31:0] exp);
        int waited = 0;
        bit done   = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_imm   = imm;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(exp);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 50) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL send_timeout: in_ready got 0, expected 1");
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready_hold", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_release_out_data", bus.out_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'b00;
        bus.in_imm    = 16'h0000;
        bus.out_ready = 1'b0;
        #2;
        do_reset();

        // Extension modes
        bus.out_ready = 1'b1;
        send(2'b00, 16'h8001, 32'h00008001);
        send(2'b01, 16'h8001, 32'hFFFF8001);
        send(2'b10, 16'h8001, 32'h80010000);
`ifdef IMM_BRANCH_MODE_EN
        send(2'b11, 16'h8001, 32'hFFFE0004);
        send(2'b11, 16'h0003, 32'h0000000C);
`else
        send(2'b11, 16'h8001, 32'h00008001);
        send(2'b11, 16'h0003, 32'h00000003);
`endif
        send(2'b01, 16'h7FFF, 32'h00007FFF);
        send(2'b10, 16'h1234, 32'h12340000);
        drain();

        // Backpressure: third item is held until the consumer resumes
        bus.out_ready = 1'b0;
        send(2'b00, 16'h0001, 32'h00000001);
        send(2'b01, 16'hFFFE, 32'hFFFFFFFE);
        @(negedge clk);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_occupancy", 32'(bus.occupancy), 32'd2);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        fork
            send(2'b10, 16'h00AB, 32'h00AB0000);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("bp_occ_hold", 32'(bus.occupancy), 32'd2);
                chk("bp_head_hold", bus.out_data, 32'h00000001);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Streaming: one result per cycle, occupancy stays at one
        bus.out_ready = 1'b1;
        fork
            for (int i = 0; i < 8; i++) send(2'b00, 16'h0100 + 16'(i), 32'h00000100 + 32'(i));
            begin
                @(negedge clk);
                repeat (8) begin
                    @(negedge clk);
                    chk("stream_occ", 32'(bus.occupancy), 32'd1);
                end
            end
        join
        drain();

        // Flush with full buffer plus a same-cycle push
        bus.out_ready = 1'b0;
        send(2'b00, 16'h0055, 32'h00000055);
        send(2'b00, 16'h0066, 32'h00000066);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_mode  = 2'b01;
        bus.in_imm   = 16'hDEAD;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        chk("flush_occ", 32'(bus.occupancy), 32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);

        // Flush with one entry and an acceptable push: push must be dropped
        send(2'b00, 16'h0011, 32'h00000011);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_imm   = 16'hBEEF;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        chk("flush2_occ", 32'(bus.occupancy), 32'd0);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(2'b00, 16'h0077, 32'h00000077);
        drain();

        // Pointer wrap under a toggling consumer
        bus.out_ready = 1'b1;
        fork
            for (int i = 0; i < 10; i++) send(2'b01, wrap_imm[i], wrap_exp[i]);
            begin
                repeat (15) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ~bus.out_ready;
                end
                bus.out_ready = 1'b1;
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Reset asserted mid-traffic
        bus.out_ready = 1'b0;
        send(2'b00, 16'h0033, 32'h00000033);
        send(2'b00, 16'h0044, 32'h00000044);
        do_reset();
        bus.out_ready = 1'b1;
        send(2'b01, 16'h8001, 32'hFFFF8001);
        drain();
        @(negedge clk);
        chk("end_occ", 32'(bus.occupancy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
